// File: rtl/datapath_pkg.sv
// Shared opcode encoding and effective-operand rule for the arithmetic datapath.
// Both the issuer front end and any reference model import this package.
package datapath_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_ADDC  = 3'b001;
  localparam logic [2:0] OP_SUBB  = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_PASS  = 3'b100;
  localparam logic [2:0] OP_INC   = 3'b101;
  localparam logic [2:0] OP_DEC   = 3'b110;
  localparam logic [2:0] OP_PASS1 = 3'b111;

  // One bit of the effective second operand M: B is zeroed first, then inverted.
  // Working per bit keeps the function independent of the datapath width.
  function automatic logic eff_bit(input logic b, input logic force_zero, input logic invert);
    return (b & ~force_zero) ^ invert;
  endfunction

endpackage

// File: rtl/datapath_issuer_fifo.sv
// In-order result buffer: circular storage with a registered occupancy count.
// The head reads as zero while empty so the output bus idles at a known value.
module result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           pop_data,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push & ~clr;
    do_pop   = pop & (count_q != '0) & ~clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign valid    = (count_q != '0);
  assign pop_data = valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

  // Issue credits make overfilling impossible; catch it if that ever breaks.
  assert property (@(posedge clk) disable iff (!rst_n) !(do_push && (count_q == (AW+1)'(DEPTH))));

endmodule

// File: rtl/datapath_issuer.sv
// Front-end sequencer for the arithmetic datapath: issues operand triples under
// credit control, captures Y/co after the datapath latency and returns results in order.
module datapath_issuer
  import datapath_pkg::*;
#(
  parameter int N     = 16,
  parameter int PIPE  = 0,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic [2:0]      in_op,
  output logic [N-1:0]    dp_a,
  output logic [N-1:0]    dp_b,
  output logic [2:0]      dp_op,
  input  logic [N-1:0]    dp_y,
  input  logic            dp_co,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_y,
  output logic            out_co,
  output logic            out_ovf,
  output logic [TAGW-1:0] out_tag
);
  localparam int STAGES = PIPE + 1;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int FW     = N + 2 + TAGW;

  logic [N-1:0]      dp_a_q, dp_a_d;
  logic [N-1:0]      dp_b_q, dp_b_d;
  logic [2:0]        dp_op_q, dp_op_d;
  logic [TAGW-1:0]   tag_q, tag_d;

  logic [STAGES-1:0] fl_vld_q, fl_vld_d;
  logic [N-1:0]      fl_a_q   [STAGES];
  logic [N-1:0]      fl_a_d   [STAGES];
  logic [N-1:0]      fl_m_q   [STAGES];
  logic [N-1:0]      fl_m_d   [STAGES];
  logic [TAGW-1:0]   fl_tag_q [STAGES];
  logic [TAGW-1:0]   fl_tag_d [STAGES];

  logic [N-1:0]      m_eff;
  logic [N-1:0]      cap_a, cap_m;
  logic [CW-1:0]     buf_count;
  logic [CW:0]       credit_sum;
  logic              accept, push, pop, cap_ovf, buf_valid;
  logic [FW-1:0]     push_data, pop_data;

  for (genvar gi = 0; gi < N; gi++) begin : g_meff
    assign m_eff[gi] = eff_bit(in_b[gi], in_op[2], in_op[1]);
  end

  // Credits come from registered counts only, so a pop frees a slot one cycle later.
  always_comb begin
    credit_sum = {1'b0, buf_count};
    for (int i = 0; i < STAGES; i++) begin
      credit_sum = credit_sum + {{CW{1'b0}}, fl_vld_q[i]};
    end
    in_ready = rst_n & ~flush & (credit_sum < (CW+1)'(DEPTH));
    accept   = in_valid & in_ready;
  end

  always_comb begin
    dp_a_d  = dp_a_q;
    dp_b_d  = dp_b_q;
    dp_op_d = dp_op_q;
    tag_d   = tag_q;
    if (accept) begin
      dp_a_d  = in_a;
      dp_b_d  = in_b;
      dp_op_d = in_op;
      tag_d   = tag_q + 1'b1;
    end
    fl_vld_d    = '0;
    fl_vld_d[0] = accept;
    fl_a_d[0]   = in_a;
    fl_m_d[0]   = m_eff;
    fl_tag_d[0] = tag_q;
    for (int i = 1; i < STAGES; i++) begin
      fl_vld_d[i] = fl_vld_q[i-1] & ~flush;
      fl_a_d[i]   = fl_a_q[i-1];
      fl_m_d[i]   = fl_m_q[i-1];
      fl_tag_d[i] = fl_tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_a_q   <= '0;
      dp_b_q   <= '0;
      dp_op_q  <= '0;
      tag_q    <= '0;
      fl_vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        fl_a_q[i]   <= '0;
        fl_m_q[i]   <= '0;
        fl_tag_q[i] <= '0;
      end
    end else begin
      dp_a_q   <= dp_a_d;
      dp_b_q   <= dp_b_d;
      dp_op_q  <= dp_op_d;
      tag_q    <= tag_d;
      fl_vld_q <= fl_vld_d;
      for (int i = 0; i < STAGES; i++) begin
        fl_a_q[i]   <= fl_a_d[i];
        fl_m_q[i]   <= fl_m_d[i];
        fl_tag_q[i] <= fl_tag_d[i];
      end
    end
  end

  // The last chain stage lines up with the datapath result for that op.
  assign cap_a     = fl_a_q[STAGES-1];
  assign cap_m     = fl_m_q[STAGES-1];
  assign cap_ovf   = (cap_a[N-1] == cap_m[N-1]) & (dp_y[N-1] != cap_a[N-1]);
  assign push      = fl_vld_q[STAGES-1] & ~flush;
  assign push_data = {dp_y, dp_co, cap_ovf, fl_tag_q[STAGES-1]};
  assign pop       = buf_valid & out_ready;

  result_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .valid     (buf_valid),
    .count     (buf_count)
  );

  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign dp_op     = dp_op_q;
  assign out_valid = buf_valid;
  assign {out_y, out_co, out_ovf, out_tag} = pop_data;

endmodule

// File: tb/tb_datapath_issuer.sv
// Bench for datapath_issuer: runs a PIPE=0 and a PIPE=1 instance side by side on the
// same stimulus, each against a queue-based model of accepted-but-unreturned results.
module tb_datapath_issuer;
  import datapath_pkg::*;

  localparam int N     = 16;
  localparam int DEPTH = 4;
  localparam int TAGW  = 4;

  typedef struct {
    logic [N-1:0]    y;
    logic            co;
    logic            ovf;
    logic [TAGW-1:0] tag;
    int              rdy;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, flush, in_valid, out_ready;
  logic [N-1:0] in_a, in_b;
  logic [2:0]   in_op;

  int checks   = 0;
  int failures = 0;

  // Directed expectations: 1 = result fields, 2 = buffer full, 3 = buffer empty.
  int              dir_mode = 0;
  logic [N-1:0]    dir_y;
  logic            dir_co, dir_ovf;
  logic [TAGW-1:0] dir_tag;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] eff_m(input logic [N-1:0] b, input logic [2:0] op);
    logic [N-1:0] m;
    m = op[2] ? '0 : b;
    return op[1] ? ~m : m;
  endfunction

  function automatic logic [N:0] dp_calc(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [2:0] op);
    return {1'b0, a} + {1'b0, eff_m(b, op)} + {{N{1'b0}}, op[0]};
  endfunction

  function automatic logic [N-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return N'($urandom);
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    logic            in_ready, out_valid, out_co, out_ovf, dp_co;
    logic [N-1:0]    dp_a, dp_b, dp_y, out_y;
    logic [2:0]      dp_op;
    logic [TAGW-1:0] out_tag;

    res_t            q[$];
    int              cyc = 0;
    bit              started = 0;
    bit              in_rst = 0;
    logic [N-1:0]    ea, eb;
    logic [2:0]      eop;
    logic [TAGW-1:0] etag;

    datapath_issuer #(
      .N     (N),
      .PIPE  (gi),
      .DEPTH (DEPTH),
      .TAGW  (TAGW)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .dp_a      (dp_a),
      .dp_b      (dp_b),
      .dp_op     (dp_op),
      .dp_y      (dp_y),
      .dp_co     (dp_co),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_co    (out_co),
      .out_ovf   (out_ovf),
      .out_tag   (out_tag)
    );

    if (gi == 0) begin : g_dp_comb
      always_comb {dp_co, dp_y} = dp_calc(dp_a, dp_b, dp_op);
    end else begin : g_dp_reg
      always @(posedge clk) {dp_co, dp_y} <= dp_calc(dp_a, dp_b, dp_op);
    end

    initial begin : mdl
      bit           rdy_now, vld_now;
      res_t         r;
      logic [N:0]   s;
      logic [N-1:0] m;
      forever begin
        @(posedge clk);
        rdy_now = rst_n && !flush && (q.size() < DEPTH);
        vld_now = (q.size() > 0) && (q[0].rdy <= cyc);
        if (!rst_n) begin
          q.delete();
          etag    = '0;
          ea      = '0;
          eb      = '0;
          eop     = '0;
          started = 1;
          in_rst  = 1;
        end else begin
          in_rst = 0;
          if (flush) begin
            q.delete();
          end else begin
            if (vld_now && out_ready) begin
              $display("p%0d cyc=%0d pop tag=%0d y=%h co=%0b ovf=%0b",
                       gi, cyc, q[0].tag, q[0].y, q[0].co, q[0].ovf);
              void'(q.pop_front());
            end
            if (in_valid && rdy_now) begin
              s     = dp_calc(in_a, in_b, in_op);
              m     = eff_m(in_b, in_op);
              r.y   = s[N-1:0];
              r.co  = s[N];
              r.ovf = (in_a[N-1] == m[N-1]) && (r.y[N-1] != in_a[N-1]);
              r.tag = etag;
              r.rdy = cyc + gi + 2;
              q.push_back(r);
              ea   = in_a;
              eb   = in_b;
              eop  = in_op;
              etag = etag + 1'b1;
            end
          end
        end
        cyc++;
      end
    end

    initial begin : chk
      bit exp_rdy, exp_vld;
      forever begin
        @(negedge clk);
        if (started) begin
          exp_rdy = rst_n && !flush && (q.size() < DEPTH);
          exp_vld = (q.size() > 0) && (q[0].rdy <= cyc);
          check_val($sformatf("p%0d_in_ready", gi), in_ready, exp_rdy);
          check_val($sformatf("p%0d_out_valid", gi), out_valid, exp_vld);
          check_val($sformatf("p%0d_dp_a", gi), dp_a, ea);
          check_val($sformatf("p%0d_dp_b", gi), dp_b, eb);
          check_val($sformatf("p%0d_dp_op", gi), dp_op, eop);
          if (exp_vld) begin
            check_val($sformatf("p%0d_out_y", gi), out_y, q[0].y);
            check_val($sformatf("p%0d_out_co", gi), out_co, q[0].co);
            check_val($sformatf("p%0d_out_ovf", gi), out_ovf, q[0].ovf);
            check_val($sformatf("p%0d_out_tag", gi), out_tag, q[0].tag);
          end
          if (in_rst) begin
            check_val($sformatf("p%0d_rst_out_y", gi), out_y, 0);
            check_val($sformatf("p%0d_rst_out_flags", gi), {out_co, out_ovf}, 0);
            check_val($sformatf("p%0d_rst_out_tag", gi), out_tag, 0);
          end
          if (dir_mode == 1) begin
            check_val($sformatf("p%0d_dir_valid", gi), out_valid, 1);
            check_val($sformatf("p%0d_dir_y", gi), out_y, dir_y);
            check_val($sformatf("p%0d_dir_co", gi), out_co, dir_co);
            check_val($sformatf("p%0d_dir_ovf", gi), out_ovf, dir_ovf);
            check_val($sformatf("p%0d_dir_tag", gi), out_tag, dir_tag);
          end else if (dir_mode == 2) begin
            check_val($sformatf("p%0d_full_in_ready", gi), in_ready, 0);
            check_val($sformatf("p%0d_full_out_valid", gi), out_valid, 1);
          end else if (dir_mode == 3) begin
            check_val($sformatf("p%0d_flush_out_valid", gi), out_valid, 0);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One op into empty buffers, then hold it at the output and compare with constants.
  task automatic directed(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op,
                          input logic [N-1:0] ey, input logic eco, input logic eovf,
                          input logic [TAGW-1:0] etag);
    in_a      = a;
    in_b      = b;
    in_op     = op;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    dir_y    = ey;
    dir_co   = eco;
    dir_ovf  = eovf;
    dir_tag  = etag;
    dir_mode = 1;
    step();
    dir_mode  = 0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 16'h1234;
    in_b      = 16'h4321;
    in_op     = OP_ADD;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();

    directed(16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b0, 1'b1, 4'd0);
    directed(16'h0005, 16'h0007, OP_SUB, 16'hFFFE, 1'b0, 1'b0, 4'd1);
    directed(16'h0007, 16'h0005, OP_SUB, 16'h0002, 1'b1, 1'b0, 4'd2);
    directed(16'h0000, 16'h1234, OP_DEC, 16'hFFFF, 1'b0, 1'b0, 4'd3);

    // Backpressure: six ops offered against four credits.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_a     = pick_operand();
      in_b     = pick_operand();
      in_op    = 3'($urandom_range(0, 7));
      step();
    end
    in_valid = 1'b0;
    dir_mode = 2;
    step();
    dir_mode  = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_a     = pick_operand();
      in_b     = pick_operand();
      in_op    = 3'($urandom_range(0, 7));
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();

    // Flush with two buffered results and one op in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a     = pick_operand();
      in_b     = pick_operand();
      in_op    = OP_ADD;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    in_valid = 1'b1;
    in_op    = OP_SUB;
    step();
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    dir_mode = 3;
    step();
    dir_mode  = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = OP_INC;
    step();
    in_valid = 1'b0;
    repeat (4) step();

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_a      = pick_operand();
      in_b      = pick_operand();
      in_op     = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      rst_n     = ($urandom_range(0, 149) != 0);
      step();
    end
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
